// File: rtl/fp32_pkg.sv
// Shared constants, state encoding and operand classification for the FP32 divider.
// Define ROUND_NEAREST_EN for round-to-nearest-even; otherwise results are truncated.
package fp32_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam int unsigned BIAS   = 127;
    localparam int unsigned QBITS  = 26;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned EXPI_W = 10;

    localparam logic [WORD_W-1:0] QNAN = 32'h7FC0_0000;

`ifdef ROUND_NEAREST_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, NORM, DONE} state_t;

    typedef enum logic [1:0] {CLS_ZERO, CLS_NORMAL, CLS_SPECIAL} op_class_t;

    // Subnormals fold into zero; any all-ones exponent is treated as non-numeric.
    function automatic op_class_t classify(input logic [EXP_W-1:0] e);
        if (e == '0) return CLS_ZERO;
        if (&e)      return CLS_SPECIAL;
        return CLS_NORMAL;
    endfunction

endpackage

// File: rtl/fp32_divider_if.sv
// Request/response bundle between the FP sequencer (master) and the divider (slave).
interface fp32_divider_if;
    import fp32_pkg::*;

    logic              start;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] result;
    logic              div_by_zero;

    modport master (output start, a, b, input busy, done, result, div_by_zero);
    modport slave  (input start, a, b, output busy, done, result, div_by_zero);

endinterface

// File: rtl/fp_div_core.sv
// Restoring mantissa divider: one quotient bit per step, remainder kept for the sticky bit.
module fp_div_core
    import fp32_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [MANT_W:0]   dividend,
    input  logic [MANT_W:0]   divisor,
    output logic [QBITS-1:0]  q,
    output logic [MANT_W+1:0] rem
);

    logic [MANT_W:0] div_r;
    logic [MANT_W:0] diff;
    logic            fits;

    // When the divisor fits, the difference is below the divisor, so the low bits suffice.
    always_comb begin
        fits = rem >= {1'b0, div_r};
        diff = rem[MANT_W:0] - div_r;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q     <= '0;
            rem   <= '0;
            div_r <= '0;
        end else if (load) begin
            q     <= '0;
            rem   <= {1'b0, dividend};
            div_r <= divisor;
        end else if (step) begin
            q   <= {q[QBITS-2:0], fits};
            rem <= fits ? {diff, 1'b0} : {rem[MANT_W:0], 1'b0};
        end
    end

endmodule

// File: rtl/fp32_divider.sv
// Sequential IEEE-754 single-precision divider (result = a / b) with start/busy/done handshake.
// ROUND_NEAREST_EN selects round-to-nearest-even; default build truncates.
module fp32_divider
    import fp32_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    fp32_divider_if.slave bus
);

    state_t                    state;
    logic [WORD_W-1:0]         a_r, b_r;
    logic                      sign;
    logic signed [EXPI_W-1:0]  exp_r;
    logic [CNT_W-1:0]          count;
    logic                      busy, done, dbz;
    logic [WORD_W-1:0]         result;

    op_class_t                 cls_a, cls_b;
    logic                      special, special_dbz, sign_c;
    logic [WORD_W-1:0]         special_res, norm_res;
    logic                      core_load, core_step;
    logic [QBITS-1:0]          q;
    logic [MANT_W+1:0]         rem;

    logic [QBITS-1:0]          qn;
    logic signed [EXPI_W-1:0]  en;
    logic [MANT_W:0]           sig;
    logic                      guard, sticky, round_up;
    logic [MANT_W+1:0]         sum;
    logic [MANT_W-1:0]         frac;

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.result      = result;
    assign bus.div_by_zero = dbz;

    // Operand classification and the results that bypass the divider.
    always_comb begin
        cls_a       = classify(a_r[30:23]);
        cls_b       = classify(b_r[30:23]);
        sign_c      = a_r[31] ^ b_r[31];
        special     = (cls_a != CLS_NORMAL) || (cls_b != CLS_NORMAL);
        special_dbz = (cls_b == CLS_ZERO);
        if (cls_a == CLS_SPECIAL || cls_b == CLS_SPECIAL || (cls_a == CLS_ZERO && cls_b == CLS_ZERO))
            special_res = QNAN;
        else if (cls_b == CLS_ZERO)
            special_res = {sign_c, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        else
            special_res = {sign_c, {(WORD_W-1){1'b0}}};
        core_load = (state == LOAD) && !special;
        core_step = (state == DIVIDE);
    end

    fp_div_core u_core (
        .clock    (clock),
        .reset    (reset),
        .load     (core_load),
        .step     (core_step),
        .dividend ({1'b1, a_r[MANT_W-1:0]}),
        .divisor  ({1'b1, b_r[MANT_W-1:0]}),
        .q        (q),
        .rem      (rem)
    );

    // Normalise, round and pack the quotient; bit 0 of an unshifted quotient joins the sticky.
    always_comb begin
        qn = q;
        en = exp_r;
        if (!q[QBITS-1]) begin
            qn = {q[QBITS-2:0], 1'b0};
            en = exp_r - EXPI_W'(1);
        end
        sig      = qn[QBITS-1:2];
        guard    = qn[1];
        sticky   = qn[0] | (rem != '0);
        round_up = ROUND_EN & guard & (sticky | sig[0]);
        sum      = {1'b0, sig} + (MANT_W+2)'(round_up);
        if (sum[MANT_W+1]) begin
            frac = sum[MANT_W:1];
            en   = en + EXPI_W'(1);
        end else begin
            frac = sum[MANT_W-1:0];
        end
        if (en >= $signed(EXPI_W'(255)))
            norm_res = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        else if (en <= $signed(EXPI_W'(0)))
            norm_res = {sign, {(WORD_W-1){1'b0}}};
        else
            norm_res = {sign, en[EXP_W-1:0], frac};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            sign   <= 1'b0;
            exp_r  <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dbz    <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    sign  <= sign_c;
                    exp_r <= $signed({2'b00, a_r[30:23]}) - $signed({2'b00, b_r[30:23]})
                             + $signed(EXPI_W'(BIAS));
                    count <= CNT_W'(QBITS - 1);
                    if (special) begin
                        result <= special_res;
                        dbz    <= special_dbz;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (count == '0) state <= NORM;
                    else             count <= count - CNT_W'(1);
                end
                NORM: begin
                    result <= norm_res;
                    dbz    <= 1'b0;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
